// File: rtl/oddr_ser_tx.sv
// Multi-lane DDR transmit serializer: parallel words in, RATIO beat pairs per lane out
// through an oddr stage, with idle-frame fill on underrun that keeps frame alignment.

module oddr #(
    parameter string TARGET      = "GENERIC",
    parameter string IODDR_STYLE = "IODDR2",
    parameter int    WIDTH       = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q
);
    // Vendor IODDR2-style primitives register their inputs once more before the DDR cell.
    localparam bit VENDOR  = (TARGET == "XILINX") || (TARGET == "ALTERA");
    localparam bit PRE_REG = VENDOR && (IODDR_STYLE == "IODDR2");

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] r2_fall;

    generate
        if (PRE_REG) begin : g_pre
            logic [WIDTH-1:0] p1;
            logic [WIDTH-1:0] p2;
            always_ff @(posedge clk) begin
                p1 <= d1;
                p2 <= d2;
            end
            assign in1 = p1;
            assign in2 = p2;
        end else begin : g_direct
            assign in1 = d1;
            assign in2 = d2;
        end
    endgenerate

    always_ff @(posedge clk) begin
        r1 <= in1;
        r2 <= in2;
    end

    // Retime the falling-edge half so it is stable for the whole low phase.
    always_ff @(negedge clk) begin
        r2_fall <= r2;
    end

    assign q = clk ? r1 : r2_fall;
endmodule

module oddr_ser_tx #(
    parameter string      TARGET      = "GENERIC",
    parameter string      IODDR_STYLE = "IODDR2",
    parameter int         WIDTH       = 1,
    parameter int         RATIO       = 4,
    parameter logic [WIDTH-1:0] IDLE_D1 = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] IDLE_D2 = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*WIDTH*RATIO-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     frame_start,
    output logic                     underflow,
    output logic [WIDTH-1:0]         d1,
    output logic [WIDTH-1:0]         d2,
    output logic [WIDTH-1:0]         q
);
    localparam int FW = 2 * WIDTH * RATIO;
    localparam int BW = 2 * WIDTH;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST       = CW'(RATIO - 1);
    localparam logic [FW-1:0] IDLE_FRAME = {RATIO{IDLE_D2, IDLE_D1}};

    logic [CW-1:0] cnt;
    logic [FW-1:0] buf_data;
    logic          buf_valid;
    logic [FW-1:0] shreg;
    logic [FW-1:0] shreg_shift;
    logic          frame_active;
    logic          boundary;
    logic          accept;

    assign boundary = (cnt == LAST);
    assign s_ready  = !buf_valid || boundary;
    assign accept   = s_valid && s_ready;

    generate
        if (RATIO > 1) begin : g_shift
            assign shreg_shift = {{BW{1'b0}}, shreg[FW-1:BW]};
        end else begin : g_noshift
            assign shreg_shift = shreg;
        end
    endgenerate

    // Contents are qualified by buf_valid, so the data register needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            buf_valid    <= 1'b0;
            frame_active <= 1'b0;
            underflow    <= 1'b0;
            shreg        <= IDLE_FRAME;
        end else if (boundary) begin
            cnt          <= '0;
            shreg        <= buf_valid ? buf_data : IDLE_FRAME;
            frame_active <= buf_valid;
            buf_valid    <= accept;
            underflow    <= frame_active && !buf_valid;
        end else begin
            cnt       <= cnt + 1'b1;
            shreg     <= shreg_shift;
            underflow <= 1'b0;
            if (accept) begin
                buf_valid <= 1'b1;
            end
        end
    end

    assign frame_start = (cnt == '0);
    assign d1          = shreg[WIDTH-1:0];
    assign d2          = shreg[BW-1:WIDTH];

    oddr #(
        .TARGET      (TARGET),
        .IODDR_STYLE (IODDR_STYLE),
        .WIDTH       (WIDTH)
    ) u_oddr (
        .clk (clk),
        .d1  (d1),
        .d2  (d2),
        .q   (q)
    );
endmodule

// File: tb/tb_oddr_ser_tx.sv
// Bench for oddr_ser_tx: a WIDTH=2/RATIO=4 instance and a WIDTH=2/RATIO=1 instance,
// checked every cycle against a word-queue model plus hand-computed literals.

module tb_oddr_ser_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_v, a_rdy, a_fs, a_uf;
    logic [15:0] a_dat;
    logic [1:0]  a_d1, a_d2, a_q;
    logic        b_rst, b_v, b_rdy, b_fs, b_uf;
    logic [3:0]  b_dat;
    logic [1:0]  b_d1, b_d2, b_q;

    oddr_ser_tx #(.TARGET("GENERIC"), .WIDTH(2), .RATIO(4),
                  .IDLE_D1(2'b01), .IDLE_D2(2'b10)) dut_a (
        .clk(clk), .rst(a_rst), .s_data(a_dat), .s_valid(a_v), .s_ready(a_rdy),
        .frame_start(a_fs), .underflow(a_uf), .d1(a_d1), .d2(a_d2), .q(a_q));

    oddr_ser_tx #(.TARGET("GENERIC"), .WIDTH(2), .RATIO(1),
                  .IDLE_D1(2'b11), .IDLE_D2(2'b00)) dut_b (
        .clk(clk), .rst(b_rst), .s_data(b_dat), .s_valid(b_v), .s_ready(b_rdy),
        .frame_start(b_fs), .underflow(b_uf), .d1(b_d1), .d2(b_d2), .q(b_q));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: frames are whole words; cycle index since reset picks the beat.
    int          rr  [2] = '{4, 1};
    logic [1:0]  id1 [2] = '{2'b01, 2'b11};
    logic [1:0]  id2 [2] = '{2'b10, 2'b00};
    int          cyc [2];
    bit          act [2] = '{0, 0};
    logic [15:0] fw  [2];
    bit          fdat[2];
    bit          euf [2];
    logic [1:0]  pd1 [2], pd2 [2], ql [2];
    bit          qok [2] = '{0, 0};
    bit          qlok[2] = '{0, 0};
    logic [15:0] pend_a[$];
    logic [15:0] pend_b[$];

    function automatic int pend_size(input int d);
        return (d == 0) ? pend_a.size() : pend_b.size();
    endfunction

    task automatic model_edge(input int d, input logic r, input logic v, input logic [15:0] dat);
        bit b, rdy, was;
        if (r) begin
            cyc[d] = 0; act[d] = 1; fdat[d] = 0; euf[d] = 0;
            if (d == 0) pend_a.delete(); else pend_b.delete();
        end else if (act[d]) begin
            b   = (cyc[d] % rr[d]) == rr[d] - 1;
            rdy = (pend_size(d) == 0) || b;
            if (b) begin
                was = fdat[d];
                if (pend_size(d) > 0) begin
                    fdat[d] = 1;
                    if (d == 0) fw[d] = pend_a.pop_front(); else fw[d] = pend_b.pop_front();
                end else begin
                    fdat[d] = 0;
                end
                euf[d] = was && !fdat[d];
            end else begin
                euf[d] = 0;
            end
            if (v && rdy) begin
                if (d == 0) pend_a.push_back(dat); else pend_b.push_back(dat);
            end
            cyc[d]++;
        end
    endtask

    task automatic compare(input int d, input string p, input logic [1:0] od1, input logic [1:0] od2,
                           input logic [1:0] oq, input logic ordy, input logic ofs, input logic ouf);
        int k;
        logic [15:0] sh;
        logic [1:0] ed1, ed2;
        k   = cyc[d] % rr[d];
        sh  = fw[d] >> (4 * k);
        ed1 = fdat[d] ? sh[1:0] : id1[d];
        ed2 = fdat[d] ? sh[3:2] : id2[d];
        chk({p, "_d1"}, od1, ed1);
        chk({p, "_d2"}, od2, ed2);
        chk({p, "_frame_start"}, ofs, k == 0);
        chk({p, "_underflow"}, ouf, euf[d]);
        chk({p, "_s_ready"}, ordy, (pend_size(d) == 0) || (k == rr[d] - 1));
        if (qok[d]) chk({p, "_q_hi"}, oq, pd1[d]);
        ql[d] = pd2[d]; qlok[d] = qok[d];
        pd1[d] = ed1; pd2[d] = ed2; qok[d] = 1;
    endtask

    always @(posedge clk) begin
        model_edge(0, a_rst, a_v, a_dat);
        model_edge(1, b_rst, b_v, {12'h000, b_dat});
        #1;
        if (act[0]) compare(0, "A", a_d1, a_d2, a_q, a_rdy, a_fs, a_uf);
        if (act[1]) compare(1, "B", b_d1, b_d2, b_q, b_rdy, b_fs, b_uf);
    end

    always @(negedge clk) begin
        #1;
        if (qlok[0]) chk("A_q_lo", a_q, ql[0]);
        if (qlok[1]) chk("B_q_lo", b_q, ql[1]);
    end

    task automatic a_step();
        logic hs;
        hs = a_v && a_rdy;
        @(posedge clk); #2;
        if (hs) a_dat = a_dat + 16'd1;
    endtask

    logic [1:0]  lit_d1 [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [39:0] pat = 40'hB6_D93A_4C71;

    initial begin
        a_rst = 1'b1; a_v = 1'b0; a_dat = '0;
        b_rst = 1'b1; b_v = 1'b0; b_dat = '0;
        fork
            begin : seq_a
                int nrdy;
                bit found;
                repeat (3) @(posedge clk);
                #2;
                a_rst = 1'b0; a_v = 1'b1; a_dat = 16'hFEDC;
                chk("A_lit_fs_c0", a_fs, 1'b1);
                chk("A_lit_rdy_c0", a_rdy, 1'b1);
                chk("A_lit_idle_d1_c0", a_d1, 2'b01);
                chk("A_lit_idle_d2_c0", a_d2, 2'b10);
                @(posedge clk); #2;
                a_v = 1'b0;
                chk("A_lit_fs_c1", a_fs, 1'b0);
                for (int c = 2; c <= 9; c++) begin
                    @(posedge clk); #2;
                    if (c >= 4 && c <= 7) begin
                        chk("A_lit_beat_d1", a_d1, lit_d1[c-4]);
                        chk("A_lit_beat_d2", a_d2, 2'd3);
                    end
                    if (c == 8) begin
                        chk("A_lit_uf_c8", a_uf, 1'b1);
                        chk("A_lit_idle_d1_c8", a_d1, 2'b01);
                    end
                    if (c == 9) chk("A_lit_uf_c9", a_uf, 1'b0);
                end
                a_v = 1'b1; a_dat = 16'h1000; nrdy = 0;
                for (int i = 0; i < 48; i++) begin
                    a_step();
                    if (i >= 24 && i < 40) nrdy += int'(a_rdy);
                end
                chk("A_lit_ready_rate", nrdy, 4);
                for (int i = 0; i < 40; i++) begin
                    a_step();
                    a_v = pat[i];
                end
                a_v = 1'b1;
                repeat (12) a_step();
                found = 0;
                for (int i = 0; i < 8; i++) begin
                    if (a_fs) begin found = 1; break; end
                    a_step();
                end
                chk("A_lit_frame_found", found, 1'b1);
                a_step(); a_step();
                chk("A_lit_backpressure", a_rdy, 1'b0);
                a_rst = 1'b1; a_v = 1'b0;
                @(posedge clk); #2;
                chk("A_lit_rst_d1", a_d1, 2'b01);
                chk("A_lit_rst_d2", a_d2, 2'b10);
                chk("A_lit_rst_fs", a_fs, 1'b1);
                chk("A_lit_rst_rdy", a_rdy, 1'b1);
                a_rst = 1'b0;
                repeat (12) a_step();
            end
            begin : seq_b
                int nuf, nfs;
                repeat (3) @(posedge clk);
                #2;
                b_rst = 1'b0; nuf = 0; nfs = 0;
                for (int i = 0; i < 12; i++) begin
                    b_dat = 4'(6 + i);
                    b_v = (i != 7);
                    if (i == 2) begin
                        chk("B_lit_d1_c2", b_d1, 2'd2);
                        chk("B_lit_d2_c2", b_d2, 2'd1);
                    end
                    if (i == 3) chk("B_lit_q_hi_c3", b_q, 2'd2);
                    nuf += int'(b_uf);
                    nfs += int'(b_fs);
                    @(posedge clk); #2;
                end
                b_v = 1'b0;
                chk("B_lit_uf_count", nuf, 1);
                chk("B_lit_fs_count", nfs, 12);
                repeat (4) @(posedge clk);
            end
        join
        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
